// File: rtl/hf_mover_arbiter_if.sv
// Signal bundle between the section DMA engines, the block mover and the MCU
// on one side and hf_mover_arbiter on the other. The arbiter uses the master
// view. The surrounding logic or a testbench uses the slave view.
interface hf_mover_arbiter_if;
    logic [3:0]  REQ;
    logic [35:0] REQ_START;
    logic [23:0] REQ_COUNT;
    logic [91:0] REQ_PAGE;
    logic [3:0]  REQ_RD;
    logic [3:0]  REQ_ALIGN;
    logic [3:0]  GNT;
    logic [3:0]  DONE;
    logic [5:0]  DONE_COUNT;
    logic [2:0]  DONE_STATUS;
    logic        REFRESH_REQ;
    logic        REFRESH_STROBE;
    logic [8:0]  BLCK_START;
    logic [5:0]  BLCK_COUNT_REQ;
    logic [1:0]  BLCK_SECTION;
    logic [22:0] MCU_PAGE_ADDR;
    logic        BLCK_ISSUE;
    logic [1:0]  RST_MVBLCK;
    logic [1:0]  MCU_REQUEST_ALIGN;
    logic [1:0]  MCU_GRANT_ALIGN;
    logic        BLCK_WORKING;
    logic        BLCK_IRQ;
    logic        BLCK_ABRUPT_STOP;
    logic        BLCK_FRDRAM_DEVERR;
    logic [5:0]  BLCK_COUNT_SENT;

    modport master (
        input  REQ, REQ_START, REQ_COUNT, REQ_PAGE, REQ_RD, REQ_ALIGN,
        input  REFRESH_REQ, MCU_GRANT_ALIGN,
        input  BLCK_WORKING, BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR, BLCK_COUNT_SENT,
        output GNT, DONE, DONE_COUNT, DONE_STATUS, REFRESH_STROBE,
        output BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION, MCU_PAGE_ADDR,
        output BLCK_ISSUE, RST_MVBLCK, MCU_REQUEST_ALIGN
    );

    modport slave (
        output REQ, REQ_START, REQ_COUNT, REQ_PAGE, REQ_RD, REQ_ALIGN,
        output REFRESH_REQ, MCU_GRANT_ALIGN,
        output BLCK_WORKING, BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR, BLCK_COUNT_SENT,
        input  GNT, DONE, DONE_COUNT, DONE_STATUS, REFRESH_STROBE,
        input  BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION, MCU_PAGE_ADDR,
        input  BLCK_ISSUE, RST_MVBLCK, MCU_REQUEST_ALIGN
    );
endinterface

// File: rtl/hf_mover_arbiter.sv
// Round-robin scheduler that lends the single block mover and its DRAM port
// to hyperfabric sections 0-3. It follows each transaction to completion
// under a start watchdog. It reports per-transaction status and slots MCU
// refresh strobes into idle gaps between transactions.
module hf_mover_arbiter #(
    parameter int TIMEOUT = 4095
) (
    input  logic               CLK,
    input  logic               RST,
    hf_mover_arbiter_if.master bus
);

    localparam logic [1:0]  ST_IDLE       = 2'd0;
    localparam logic [1:0]  ST_GRANT_WAIT = 2'd1;
    localparam logic [1:0]  ST_RUN        = 2'd2;
    localparam logic [1:0]  ST_FINISH     = 2'd3;
    localparam logic [11:0] WD_LIMIT      = 12'(TIMEOUT);

    logic [1:0]  state;
    logic [1:0]  ptr;
    logic [3:0]  mask;
    logic        refresh_pending;
    logic [11:0] wd;
    logic        working_q;
    logic        seen_working;

    logic [3:0]  gnt_q;
    logic [3:0]  done_q;
    logic [5:0]  done_count_q;
    logic [2:0]  done_status_q;
    logic        strobe_q;
    logic [8:0]  start_q;
    logic [5:0]  count_q;
    logic [1:0]  section_q;
    logic [22:0] page_q;
    logic        issue_q;
    logic [1:0]  rst_mv_q;
    logic [1:0]  align_q;

    logic [3:0]  eligible;
    logic        win_valid;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic        grant_hit;
    logic        wd_expired;
    logic        work_fell;

    assign eligible   = bus.REQ & ~mask;
    assign grant_hit  = |(bus.MCU_GRANT_ALIGN & align_q);
    assign wd_expired = (wd == WD_LIMIT);
    assign work_fell  = seen_working && working_q && !bus.BLCK_WORKING;

    // Pick the first eligible requester after the last winner, wrapping mod 4
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!win_valid && eligible[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Refresh request latch: a new pulse beats the clear, extra pulses merge
    always_ff @(posedge CLK) begin
        if (RST) begin
            refresh_pending <= 1'b0;
        end else if (bus.REFRESH_REQ) begin
            refresh_pending <= 1'b1;
        end else if (state == ST_IDLE) begin
            refresh_pending <= 1'b0;
        end
    end

    // Transaction sequencer: arbitrate, wait for MCU, run, then report
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            ptr           <= 2'd3;
            mask          <= 4'b0;
            wd            <= 12'd0;
            working_q     <= 1'b0;
            seen_working  <= 1'b0;
            gnt_q         <= 4'b0;
            done_q        <= 4'b0;
            done_count_q  <= 6'd0;
            done_status_q <= 3'd0;
            strobe_q      <= 1'b0;
            start_q       <= 9'd0;
            count_q       <= 6'd0;
            section_q     <= 2'd0;
            page_q        <= 23'd0;
            issue_q       <= 1'b0;
            rst_mv_q      <= 2'b0;
            align_q       <= 2'b0;
        end else begin
            issue_q <= 1'b0;
            done_q  <= 4'b0;
            case (state)
                ST_IDLE: begin
                    mask <= 4'b0;
                    if (refresh_pending) begin
                        strobe_q <= ~strobe_q;
                    end else if (win_valid) begin
                        gnt_q     <= 4'b0001 << win_idx;
                        section_q <= win_idx;
                        start_q   <= bus.REQ_START[9*win_idx +: 9];
                        count_q   <= bus.REQ_COUNT[6*win_idx +: 6];
                        page_q    <= bus.REQ_PAGE[23*win_idx +: 23];
                        rst_mv_q  <= {bus.REQ_RD[win_idx], ~bus.REQ_RD[win_idx]};
                        align_q   <= bus.REQ_ALIGN[win_idx] ? 2'b10 : 2'b01;
                        wd        <= 12'd0;
                        state     <= ST_GRANT_WAIT;
                    end
                end
                ST_GRANT_WAIT: begin
                    if (grant_hit) begin
                        issue_q      <= 1'b1;
                        working_q    <= 1'b0;
                        seen_working <= 1'b0;
                        state        <= ST_RUN;
                    end else if (wd_expired) begin
                        done_q        <= gnt_q;
                        done_count_q  <= 6'd0;
                        done_status_q <= 3'b001;
                        gnt_q         <= 4'b0;
                        align_q       <= 2'b0;
                        rst_mv_q      <= 2'b0;
                        state         <= ST_FINISH;
                    end else begin
                        wd <= wd + 12'd1;
                    end
                end
                ST_RUN: begin
                    working_q <= bus.BLCK_WORKING;
                    if (bus.BLCK_WORKING) begin
                        seen_working <= 1'b1;
                    end
                    if (work_fell) begin
                        done_q        <= gnt_q;
                        done_count_q  <= bus.BLCK_COUNT_SENT;
                        done_status_q <= {bus.BLCK_IRQ,
                                          bus.BLCK_ABRUPT_STOP | bus.BLCK_FRDRAM_DEVERR,
                                          1'b0};
                        gnt_q         <= 4'b0;
                        align_q       <= 2'b0;
                        rst_mv_q      <= 2'b0;
                        state         <= ST_FINISH;
                    end else if (!seen_working && wd_expired) begin
                        done_q        <= gnt_q;
                        done_count_q  <= 6'd0;
                        done_status_q <= 3'b001;
                        gnt_q         <= 4'b0;
                        align_q       <= 2'b0;
                        rst_mv_q      <= 2'b0;
                        state         <= ST_FINISH;
                    end else if (!seen_working) begin
                        wd <= wd + 12'd1;
                    end
                end
                ST_FINISH: begin
                    ptr   <= section_q;
                    mask  <= 4'b0001 << section_q;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.GNT               = gnt_q;
    assign bus.DONE              = done_q;
    assign bus.DONE_COUNT        = done_count_q;
    assign bus.DONE_STATUS       = done_status_q;
    assign bus.REFRESH_STROBE    = strobe_q;
    assign bus.BLCK_START        = start_q;
    assign bus.BLCK_COUNT_REQ    = count_q;
    assign bus.BLCK_SECTION      = section_q;
    assign bus.MCU_PAGE_ADDR     = page_q;
    assign bus.BLCK_ISSUE        = issue_q;
    assign bus.RST_MVBLCK        = rst_mv_q;
    assign bus.MCU_REQUEST_ALIGN = align_q;

endmodule

// File: tb/tb_hf_mover_arbiter.sv
// Self-checking bench for hf_mover_arbiter: directed scenarios plus randomized
// transactions checked against a round-robin transaction-level model.
module tb_hf_mover_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   fails = 0;
    int   rr_last = 3;

    logic [8:0]  m_start [4];
    logic [5:0]  m_count [4];
    logic [22:0] m_page  [4];
    logic        m_rd    [4];
    logic        m_align [4];

    hf_mover_arbiter_if bus_if ();

    hf_mover_arbiter #(.TIMEOUT(15)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1, "[TB] aborted");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (req[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_desc(input int s, input logic [8:0] st, input logic [5:0] cn,
                            input logic [22:0] pg, input logic rd, input logic al);
        bus_if.REQ_START[s*9 +: 9]   = st;
        bus_if.REQ_COUNT[s*6 +: 6]   = cn;
        bus_if.REQ_PAGE[s*23 +: 23]  = pg;
        bus_if.REQ_RD[s]             = rd;
        bus_if.REQ_ALIGN[s]          = al;
        m_start[s] = st;
        m_count[s] = cn;
        m_page[s]  = pg;
        m_rd[s]    = rd;
        m_align[s] = al;
    endtask

    task automatic idle_gap();
        bus_if.REQ = 4'b0;
        repeat (3) tick();
    endtask

    task automatic mstep(inout int iss, inout int tog, inout logic prev);
        tick();
        if (bus_if.BLCK_ISSUE === 1'b1) iss++;
        if (bus_if.REFRESH_STROBE !== prev) tog++;
        prev = bus_if.REFRESH_STROBE;
    endtask

    // Plays the MCU and block mover for one transaction whose GNT was just seen.
    task automatic mover_txn(
        input int gdelay, input int wdelay, input int wlen, input logic [1:0] galign,
        input logic [5:0] sent, input logic irq, input logic abrt, input logic dev,
        input int pulses,
        output int issues, output int toggles, output logic [3:0] done_v,
        output logic [5:0] dcnt, output logic [2:0] dstat,
        output logic [3:0] gnt_v, output logic [1:0] align_v);
        logic prev;
        issues  = 0;
        toggles = 0;
        prev    = bus_if.REFRESH_STROBE;
        bus_if.MCU_GRANT_ALIGN = ~galign;
        for (int i = 0; i < gdelay; i++) mstep(issues, toggles, prev);
        bus_if.MCU_GRANT_ALIGN = galign;
        mstep(issues, toggles, prev);
        bus_if.MCU_GRANT_ALIGN = 2'b00;
        for (int i = 0; i < wdelay; i++) mstep(issues, toggles, prev);
        bus_if.BLCK_WORKING = 1'b1;
        for (int i = 0; i < wlen; i++) begin
            bus_if.REFRESH_REQ = (pulses >= 1 && i == 0) || (pulses >= 2 && i == 2);
            mstep(issues, toggles, prev);
        end
        bus_if.REFRESH_REQ        = 1'b0;
        bus_if.BLCK_WORKING       = 1'b0;
        bus_if.BLCK_COUNT_SENT    = sent;
        bus_if.BLCK_IRQ           = irq;
        bus_if.BLCK_ABRUPT_STOP   = abrt;
        bus_if.BLCK_FRDRAM_DEVERR = dev;
        mstep(issues, toggles, prev);
        done_v  = bus_if.DONE;
        dcnt    = bus_if.DONE_COUNT;
        dstat   = bus_if.DONE_STATUS;
        gnt_v   = bus_if.GNT;
        align_v = bus_if.MCU_REQUEST_ALIGN;
        bus_if.BLCK_COUNT_SENT    = 6'd0;
        bus_if.BLCK_IRQ           = 1'b0;
        bus_if.BLCK_ABRUPT_STOP   = 1'b0;
        bus_if.BLCK_FRDRAM_DEVERR = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus_if.GNT !== 4'b0) begin
            fails++; $display("[TB] FAIL reset_gnt: got %b, required 0000", bus_if.GNT);
        end
        checks++;
        if ({bus_if.DONE, bus_if.DONE_COUNT, bus_if.DONE_STATUS} !== 13'd0) begin
            fails++; $display("[TB] FAIL reset_done: got %h, required 0",
                              {bus_if.DONE, bus_if.DONE_COUNT, bus_if.DONE_STATUS});
        end
        checks++;
        if ({bus_if.REFRESH_STROBE, bus_if.BLCK_ISSUE} !== 2'b00) begin
            fails++; $display("[TB] FAIL reset_strobe_issue: got %b, required 00",
                              {bus_if.REFRESH_STROBE, bus_if.BLCK_ISSUE});
        end
        checks++;
        if ({bus_if.RST_MVBLCK, bus_if.MCU_REQUEST_ALIGN} !== 4'b0) begin
            fails++; $display("[TB] FAIL reset_mover_mcu: got %b, required 0000",
                              {bus_if.RST_MVBLCK, bus_if.MCU_REQUEST_ALIGN});
        end
        checks++;
        if ({bus_if.BLCK_START, bus_if.BLCK_COUNT_REQ, bus_if.BLCK_SECTION, bus_if.MCU_PAGE_ADDR} !== 40'd0) begin
            fails++; $display("[TB] FAIL reset_descriptor: got %h, required 0",
                              {bus_if.BLCK_START, bus_if.BLCK_COUNT_REQ, bus_if.BLCK_SECTION, bus_if.MCU_PAGE_ADDR});
        end
        RST = 1'b0;
        rr_last = 3;
        tick();
    endtask

    task automatic test_round_robin();
        int iss, tog, waited, exp_w, prev_w;
        logic [3:0] dv, gv;
        logic [5:0] dc;
        logic [2:0] ds;
        logic [1:0] av;
        prev_w = -1;
        for (int s = 0; s < 4; s++) set_desc(s, 9'(s + 3), 6'(s + 1), 23'(s * 100), 1'b0, s[0]);
        bus_if.REQ = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_w  = rr_pick(4'b1111, rr_last);
            waited = 0;
            while (bus_if.GNT === 4'b0 && waited < 10) begin
                tick();
                waited++;
            end
            checks++;
            if (waited != ((t == 0) ? 1 : 2)) begin
                fails++; $display("[TB] FAIL rr_latency[%0d]: got %0d cycles, required %0d",
                                  t, waited, (t == 0) ? 1 : 2);
            end
            checks++;
            if (bus_if.GNT !== 4'(1 << exp_w)) begin
                fails++; $display("[TB] FAIL rr_order[%0d]: got %b, required %b", t, bus_if.GNT, 4'(1 << exp_w));
            end
            checks++;
            if (prev_w >= 0 && bus_if.GNT === 4'(1 << prev_w)) begin
                fails++; $display("[TB] FAIL rr_repeat[%0d]: got %b, required a section other than %0d",
                                  t, bus_if.GNT, prev_w);
            end
            mover_txn(1, 1, 3, m_align[exp_w] ? 2'b10 : 2'b01, 6'(t), 1'b0, 1'b0, 1'b0, 0,
                      iss, tog, dv, dc, ds, gv, av);
            checks++;
            if (dv !== 4'(1 << exp_w)) begin
                fails++; $display("[TB] FAIL rr_done[%0d]: got %b, required %b", t, dv, 4'(1 << exp_w));
            end
            prev_w  = exp_w;
            rr_last = exp_w;
        end
        idle_gap();
    endtask

    task automatic test_single();
        int iss, tog;
        logic [3:0] dv, gv;
        logic [5:0] dc;
        logic [2:0] ds;
        logic [1:0] av;
        set_desc(1, 9'h1a, 6'h10, 23'h12345, 1'b1, 1'b1);
        bus_if.REQ = 4'b0010;
        tick();
        checks++;
        if (bus_if.GNT !== 4'b0010) begin
            fails++; $display("[TB] FAIL single_gnt: got %b, required 0010", bus_if.GNT);
        end
        checks++;
        if (bus_if.MCU_REQUEST_ALIGN !== 2'b10 || bus_if.RST_MVBLCK !== 2'b10) begin
            fails++; $display("[TB] FAIL single_align_rst: got align %b rst %b, required 10 10",
                              bus_if.MCU_REQUEST_ALIGN, bus_if.RST_MVBLCK);
        end
        checks++;
        if ({bus_if.BLCK_SECTION, bus_if.BLCK_START, bus_if.BLCK_COUNT_REQ, bus_if.MCU_PAGE_ADDR}
            !== {2'd1, 9'h1a, 6'h10, 23'h12345}) begin
            fails++; $display("[TB] FAIL single_descriptor: got %0d %h %h %h, required 1 1a 10 12345",
                              bus_if.BLCK_SECTION, bus_if.BLCK_START, bus_if.BLCK_COUNT_REQ, bus_if.MCU_PAGE_ADDR);
        end
        mover_txn(2, 1, 20, 2'b10, 6'h10, 1'b0, 1'b0, 1'b0, 0, iss, tog, dv, dc, ds, gv, av);
        checks++;
        if (iss != 1) begin
            fails++; $display("[TB] FAIL single_issue: got %0d pulses, required 1", iss);
        end
        checks++;
        if (dv !== 4'b0010 || dc !== 6'h10 || ds !== 3'b000) begin
            fails++; $display("[TB] FAIL single_done: got %b %h %b, required 0010 10 000", dv, dc, ds);
        end
        checks++;
        if (gv !== 4'b0 || av !== 2'b0) begin
            fails++; $display("[TB] FAIL single_release: got gnt %b align %b, required 0000 00", gv, av);
        end
        rr_last = 1;
        idle_gap();
    endtask

    task automatic test_mask();
        int iss, tog, waited;
        logic [3:0] dv, gv;
        logic [5:0] dc;
        logic [2:0] ds;
        logic [1:0] av;
        set_desc(0, 9'h033, 6'h05, 23'h000777, 1'b0, 1'b0);
        bus_if.REQ = 4'b0001;
        tick();
        mover_txn(0, 0, 2, 2'b01, 6'h05, 1'b0, 1'b0, 1'b0, 0, iss, tog, dv, dc, ds, gv, av);
        waited = 0;
        while (bus_if.GNT === 4'b0 && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if (waited != 3 || bus_if.GNT !== 4'b0001) begin
            fails++; $display("[TB] FAIL mask_regrant: got %b after %0d cycles, required 0001 after 3",
                              bus_if.GNT, waited);
        end
        mover_txn(0, 0, 2, 2'b01, 6'h05, 1'b0, 1'b0, 1'b0, 0, iss, tog, dv, dc, ds, gv, av);
        rr_last = 0;
        idle_gap();
    endtask

    task automatic test_refresh();
        int iss, tog, total;
        logic s0;
        logic [3:0] dv, gv;
        logic [5:0] dc;
        logic [2:0] ds;
        logic [1:0] av;
        set_desc(2, 9'h100, 6'h08, 23'h0abcde, 1'b0, 1'b0);
        set_desc(0, 9'h001, 6'h02, 23'h000010, 1'b1, 1'b1);
        s0 = bus_if.REFRESH_STROBE;
        bus_if.REQ = 4'b0100;
        tick();
        mover_txn(1, 0, 5, 2'b01, 6'h08, 1'b0, 1'b0, 1'b0, 1, iss, tog, dv, dc, ds, gv, av);
        checks++;
        if (tog != 0 || dv !== 4'b0100) begin
            fails++; $display("[TB] FAIL refresh_busy: got %0d toggles done %b, required 0 toggles done 0100", tog, dv);
        end
        bus_if.REQ = 4'b0001;
        tick();
        checks++;
        if (bus_if.REFRESH_STROBE !== s0) begin
            fails++; $display("[TB] FAIL refresh_finish: got %b, required %b", bus_if.REFRESH_STROBE, s0);
        end
        tick();
        checks++;
        if (bus_if.REFRESH_STROBE !== ~s0 || bus_if.GNT !== 4'b0) begin
            fails++; $display("[TB] FAIL refresh_toggle: got strobe %b gnt %b, required %b 0000",
                              bus_if.REFRESH_STROBE, bus_if.GNT, ~s0);
        end
        tick();
        checks++;
        if (bus_if.GNT !== 4'b0001 || bus_if.REFRESH_STROBE !== ~s0) begin
            fails++; $display("[TB] FAIL refresh_next_gnt: got gnt %b strobe %b, required 0001 %b",
                              bus_if.GNT, bus_if.REFRESH_STROBE, ~s0);
        end
        mover_txn(0, 1, 2, 2'b10, 6'h02, 1'b0, 1'b0, 1'b0, 0, iss, tog, dv, dc, ds, gv, av);
        idle_gap();
        bus_if.REQ = 4'b0100;
        tick();
        mover_txn(0, 0, 6, 2'b01, 6'h08, 1'b0, 1'b0, 1'b0, 2, iss, tog, dv, dc, ds, gv, av);
        bus_if.REQ = 4'b0;
        total = tog;
        s0 = bus_if.REFRESH_STROBE;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.REFRESH_STROBE !== s0) total++;
            s0 = bus_if.REFRESH_STROBE;
        end
        checks++;
        if (total != 1) begin
            fails++; $display("[TB] FAIL refresh_merge: got %0d toggles, required 1", total);
        end
        rr_last = 2;
        idle_gap();
    endtask

    task automatic test_watchdog();
        int n, iss;
        set_desc(3, 9'h1ff, 6'h3f, 23'h7fffff, 1'b1, 1'b1);
        bus_if.REQ = 4'b1000;
        tick();
        bus_if.BLCK_COUNT_SENT = 6'h2a;
        bus_if.MCU_GRANT_ALIGN = 2'b01;
        n = 0;
        iss = 0;
        while (bus_if.DONE === 4'b0 && n < 40) begin
            tick();
            n++;
            if (bus_if.BLCK_ISSUE === 1'b1) iss++;
        end
        checks++;
        if (n != 16 || iss != 0) begin
            fails++; $display("[TB] FAIL wd_latency: got DONE after %0d cycles with %0d issues, required 16 and 0", n, iss);
        end
        checks++;
        if (bus_if.DONE !== 4'b1000 || bus_if.DONE_STATUS !== 3'b001 || bus_if.DONE_COUNT !== 6'd0) begin
            fails++; $display("[TB] FAIL wd_status: got %b %b %h, required 1000 001 00",
                              bus_if.DONE, bus_if.DONE_STATUS, bus_if.DONE_COUNT);
        end
        checks++;
        if (bus_if.MCU_REQUEST_ALIGN !== 2'b0 || bus_if.GNT !== 4'b0) begin
            fails++; $display("[TB] FAIL wd_release: got align %b gnt %b, required 00 0000",
                              bus_if.MCU_REQUEST_ALIGN, bus_if.GNT);
        end
        bus_if.BLCK_COUNT_SENT = 6'd0;
        bus_if.MCU_GRANT_ALIGN = 2'b00;
        rr_last = 3;
        idle_gap();
    endtask

    task automatic test_error_status();
        int iss, tog;
        logic [3:0] dv, gv;
        logic [5:0] dc;
        logic [2:0] ds;
        logic [1:0] av;
        set_desc(2, 9'h055, 6'h0c, 23'h012000, 1'b0, 1'b0);
        bus_if.REQ = 4'b0100;
        tick();
        checks++;
        if (bus_if.RST_MVBLCK !== 2'b01 || bus_if.MCU_REQUEST_ALIGN !== 2'b01) begin
            fails++; $display("[TB] FAIL err_write_dir: got rst %b align %b, required 01 01",
                              bus_if.RST_MVBLCK, bus_if.MCU_REQUEST_ALIGN);
        end
        mover_txn(0, 2, 4, 2'b01, 6'h07, 1'b1, 1'b0, 1'b1, 0, iss, tog, dv, dc, ds, gv, av);
        checks++;
        if (ds !== 3'b110 || dc !== 6'h07 || dv !== 4'b0100) begin
            fails++; $display("[TB] FAIL err_status: got %b %h %b, required 110 07 0100", ds, dc, dv);
        end
        rr_last = 2;
        idle_gap();
    endtask

    task automatic test_reset_in_run();
        int iss, tog, exp_w;
        logic s0, any_done;
        logic [3:0] dv, gv;
        logic [5:0] dc;
        logic [2:0] ds;
        logic [1:0] av;
        s0 = bus_if.REFRESH_STROBE;
        bus_if.REFRESH_REQ = 1'b1;
        tick();
        bus_if.REFRESH_REQ = 1'b0;
        checks++;
        if (bus_if.REFRESH_STROBE !== s0) begin
            fails++; $display("[TB] FAIL refresh_r1: got %b, required %b", bus_if.REFRESH_STROBE, s0);
        end
        tick();
        checks++;
        if (bus_if.REFRESH_STROBE !== ~s0) begin
            fails++; $display("[TB] FAIL refresh_r2: got %b, required %b", bus_if.REFRESH_STROBE, ~s0);
        end
        set_desc(1, 9'h0f0, 6'h11, 23'h054321, 1'b1, 1'b0);
        set_desc(0, 9'h00f, 6'h22, 23'h012345, 1'b0, 1'b1);
        set_desc(3, 9'h1f0, 6'h33, 23'h0fedcb, 1'b1, 1'b1);
        bus_if.REQ = 4'b0010;
        tick();
        bus_if.MCU_GRANT_ALIGN = 2'b01;
        tick();
        bus_if.MCU_GRANT_ALIGN = 2'b00;
        bus_if.BLCK_WORKING = 1'b1;
        repeat (3) tick();
        RST = 1'b1;
        tick();
        checks++;
        if ({bus_if.GNT, bus_if.MCU_REQUEST_ALIGN, bus_if.RST_MVBLCK, bus_if.REFRESH_STROBE, bus_if.DONE} !== 13'd0) begin
            fails++; $display("[TB] FAIL rst_run_outputs: got gnt %b align %b rst %b strobe %b done %b, required all 0",
                              bus_if.GNT, bus_if.MCU_REQUEST_ALIGN, bus_if.RST_MVBLCK, bus_if.REFRESH_STROBE, bus_if.DONE);
        end
        RST = 1'b0;
        bus_if.BLCK_WORKING = 1'b0;
        bus_if.REQ = 4'b0;
        rr_last = 3;
        any_done = 1'b0;
        repeat (4) begin
            tick();
            if (bus_if.DONE !== 4'b0) any_done = 1'b1;
        end
        checks++;
        if (any_done !== 1'b0) begin
            fails++; $display("[TB] FAIL rst_run_no_done: got DONE after reset, required none");
        end
        exp_w = rr_pick(4'b1001, rr_last);
        bus_if.REQ = 4'b1001;
        tick();
        checks++;
        if (bus_if.GNT !== 4'(1 << exp_w)) begin
            fails++; $display("[TB] FAIL rst_run_priority: got %b, required %b", bus_if.GNT, 4'(1 << exp_w));
        end
        mover_txn(0, 0, 2, 2'b10, 6'h22, 1'b0, 1'b0, 1'b0, 0, iss, tog, dv, dc, ds, gv, av);
        rr_last = exp_w;
        idle_gap();
    endtask

    task automatic test_random();
        int iss, tog, w;
        logic [3:0] req, dv, gv;
        logic [5:0] dc, sent;
        logic [2:0] ds;
        logic [1:0] av, ea;
        logic irq, abrt, dev;
        for (int t = 0; t < 40; t++) begin
            for (int s = 0; s < 4; s++) begin
                set_desc(s, 9'($urandom), 6'($urandom), 23'($urandom), 1'($urandom), 1'($urandom));
            end
            req  = 4'($urandom_range(1, 15));
            w    = rr_pick(req, rr_last);
            ea   = m_align[w] ? 2'b10 : 2'b01;
            sent = 6'($urandom);
            irq  = ($urandom_range(0, 3) == 0);
            abrt = ($urandom_range(0, 3) == 0);
            dev  = ($urandom_range(0, 3) == 0);
            bus_if.REQ = req;
            tick();
            checks++;
            if (bus_if.GNT !== 4'(1 << w) || bus_if.BLCK_SECTION !== 2'(w)) begin
                fails++; $display("[TB] FAIL rand_gnt[%0d]: got %b sec %0d, required %b sec %0d",
                                  t, bus_if.GNT, bus_if.BLCK_SECTION, 4'(1 << w), w);
            end
            checks++;
            if ({bus_if.BLCK_START, bus_if.BLCK_COUNT_REQ, bus_if.MCU_PAGE_ADDR} !== {m_start[w], m_count[w], m_page[w]}) begin
                fails++; $display("[TB] FAIL rand_desc[%0d]: got %h %h %h, required %h %h %h", t,
                                  bus_if.BLCK_START, bus_if.BLCK_COUNT_REQ, bus_if.MCU_PAGE_ADDR,
                                  m_start[w], m_count[w], m_page[w]);
            end
            checks++;
            if (bus_if.RST_MVBLCK !== {m_rd[w], ~m_rd[w]} || bus_if.MCU_REQUEST_ALIGN !== ea) begin
                fails++; $display("[TB] FAIL rand_mcu[%0d]: got rst %b align %b, required %b %b",
                                  t, bus_if.RST_MVBLCK, bus_if.MCU_REQUEST_ALIGN, {m_rd[w], ~m_rd[w]}, ea);
            end
            mover_txn($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(1, 8), ea,
                      sent, irq, abrt, dev, 0, iss, tog, dv, dc, ds, gv, av);
            checks++;
            if (iss != 1 || dv !== 4'(1 << w)) begin
                fails++; $display("[TB] FAIL rand_issue_done[%0d]: got %0d issues done %b, required 1 and %b",
                                  t, iss, dv, 4'(1 << w));
            end
            checks++;
            if (dc !== sent || ds !== {irq, abrt | dev, 1'b0}) begin
                fails++; $display("[TB] FAIL rand_status[%0d]: got %h %b, required %h %b",
                                  t, dc, ds, sent, {irq, abrt | dev, 1'b0});
            end
            rr_last = w;
            idle_gap();
        end
    endtask

    initial begin
        bus_if.REQ                = 4'b0;
        bus_if.REQ_START          = '0;
        bus_if.REQ_COUNT          = '0;
        bus_if.REQ_PAGE           = '0;
        bus_if.REQ_RD             = '0;
        bus_if.REQ_ALIGN          = '0;
        bus_if.REFRESH_REQ        = 1'b0;
        bus_if.MCU_GRANT_ALIGN    = 2'b0;
        bus_if.BLCK_WORKING       = 1'b0;
        bus_if.BLCK_IRQ           = 1'b0;
        bus_if.BLCK_ABRUPT_STOP   = 1'b0;
        bus_if.BLCK_FRDRAM_DEVERR = 1'b0;
        bus_if.BLCK_COUNT_SENT    = 6'd0;
        test_reset();
        test_round_robin();
        test_single();
        test_mask();
        test_refresh();
        test_watchdog();
        test_error_status();
        test_reset_in_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
